// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
// Optional parity support is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int CLK_DIV_MIN   = 2;

    // Wide enough to index any legal payload bit
    localparam int IDX_W = $clog2(DATA_BITS_MAX);

`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    localparam int PARITY_BITS = 0;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

    // Frame length in bit periods: start + payload + optional parity + stop bits
    function automatic int frame_bit_periods(input int data_bits, input int stop_bits);
        return 1 + data_bits + PARITY_BITS + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clk cycles while a frame is running and
// pulses bit_tick on the last cycle of every bit period.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_tick
);

    localparam int CNT_W = (CLK_DIV >= CLK_DIV_MIN) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick = run && (cnt_q == CNT_LAST);

    // Next count: held at zero when idle, wraps at the end of each bit period
    always_comb begin
        cnt_d = cnt_q;
        if (!run || bit_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input handshake and a
// registered serial output. Define UART_TX_PARITY_EN to insert a parity bit
// (even, or odd when PARITY_ODD=1) between the payload and the stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 434,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be within 5..9");
    end
    if (CLK_DIV < CLK_DIV_MIN) begin : g_bad_clk_div
        $error("uart_tx_param: CLK_DIV must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_param: PARITY_ODD must be 0 or 1");
    end
    if (frame_bit_periods(DATA_BITS, STOP_BITS) > frame_bit_periods(DATA_BITS_MAX, 2)) begin : g_bad_frame
        $error("uart_tx_param: frame longer than the largest legal frame");
    end

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             PODD      = 1'(PARITY_ODD);

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   stop_q, stop_d;
    logic                   tx_q, tx_d;
    logic                   bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .run      (state_q != IDLE),
        .bit_tick (bit_tick)
    );

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;

    // Frame sequencing: next state, shift register and the next serial bit
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        stop_d   = stop_q;
        tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    idx_d    = '0;
                    stop_d   = 1'b0;
                    tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^tx_data) ^ PODD;
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // shift_q[1] becomes the new LSB after the shift
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            stop_q   <= 1'b0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            stop_q   <= stop_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four configurations side by side,
// a frame-level reference model compared every cycle, plus literal frames.
module tb_uart_tx_param;

    localparam int N = 4;
    localparam int CD [N] = '{4, 4, 3, 4};
    localparam int DB [N] = '{8, 8, 5, 8};
    localparam int SB [N] = '{1, 2, 1, 1};
    localparam int PO [N] = '{0, 0, 1, 1};

`ifdef UART_TX_PARITY_EN
    localparam logic [15:0] P55  = 16'h04AA;
    localparam logic [15:0] P00  = 16'h0C00;
    localparam logic [15:0] P1F  = 16'h00BE;
    localparam logic [15:0] PA5E = 16'h054A;
    localparam logic [15:0] PA5O = 16'h074A;
    localparam logic [15:0] P3C  = 16'h0478;
    localparam logic [15:0] P80  = 16'h0700;
    localparam int L8S1 = 11;
    localparam int L8S2 = 12;
    localparam int L5S1 = 8;
`else
    localparam logic [15:0] P55  = 16'h02AA;
    localparam logic [15:0] P00  = 16'h0600;
    localparam logic [15:0] P1F  = 16'h007E;
    localparam logic [15:0] PA5E = 16'h034A;
    localparam logic [15:0] PA5O = 16'h034A;
    localparam logic [15:0] P3C  = 16'h0278;
    localparam logic [15:0] P80  = 16'h0300;
    localparam int L8S1 = 10;
    localparam int L8S2 = 11;
    localparam int L5S1 = 7;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] valid = '0;
    logic [8:0]   data [N];
    logic [N-1:0] ready;
    logic [N-1:0] txo;
    logic [N-1:0] busy;

    int errors = 0;
    int checks = 0;

    // Reference model: expected bit sequence of the frame in flight per DUT
    bit          act  [N];
    int          pos  [N];
    int          nb   [N];
    logic [15:0] fbits [N];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .reset(rst), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
        .tx_ready(ready[0]), .tx(txo[0]), .busy(busy[0]));
    uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
        .clk(clk), .reset(rst), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
        .tx_ready(ready[1]), .tx(txo[1]), .busy(busy[1]));
    uart_tx_param #(.DATA_BITS(5), .CLK_DIV(3), .STOP_BITS(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .reset(rst), .tx_valid(valid[2]), .tx_data(data[2][4:0]),
        .tx_ready(ready[2]), .tx(txo[2]), .busy(busy[2]));
    uart_tx_param #(.DATA_BITS(8), .CLK_DIV(4), .STOP_BITS(1), .PARITY_ODD(1)) u3 (
        .clk(clk), .reset(rst), .tx_valid(valid[3]), .tx_data(data[3][7:0]),
        .tx_ready(ready[3]), .tx(txo[3]), .busy(busy[3]));

    task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, actual, expected);
        end
    endtask

    // Build the frame: start 0, payload LSB first, optional parity, stop ones
    function automatic void load(input int k, input logic [8:0] d);
        int n;
        fbits[k] = '1;
        fbits[k][0] = 1'b0;
        for (int i = 0; i < DB[k]; i++) fbits[k][1 + i] = d[i];
        n = 1 + DB[k];
`ifdef UART_TX_PARITY_EN
        begin
            logic p;
            p = (PO[k] != 0);
            for (int i = 0; i < DB[k]; i++) p = p ^ d[i];
            fbits[k][n] = p;
            n++;
        end
`endif
        nb[k] = n + SB[k];
    endfunction

    initial begin : model
        for (int k = 0; k < N; k++) begin
            act[k] = 1'b0;
            pos[k] = 0;
            nb[k]  = 1;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < N; k++) begin
                if (rst) begin
                    act[k] = 1'b0;
                end else if (act[k]) begin
                    pos[k]++;
                    if (pos[k] == nb[k] * CD[k]) act[k] = 1'b0;
                end else if (valid[k]) begin
                    load(k, data[k]);
                    act[k] = 1'b1;
                    pos[k] = 0;
                end
            end
            #1;
            if (!rst) begin
                for (int k = 0; k < N; k++) begin
                    chk($sformatf("model_tx%0d_t%0t", k, $time), 32'(txo[k]),
                        act[k] ? 32'(fbits[k][pos[k] / CD[k]]) : 32'd1);
                    chk($sformatf("model_ready%0d", k), 32'(ready[k]), act[k] ? 32'd0 : 32'd1);
                    chk($sformatf("model_busy%0d", k), 32'(busy[k]), act[k] ? 32'd1 : 32'd0);
                end
            end
        end
    end

    // From the first negedge after acceptance: mid-bit literals and frame length
    task automatic watch(input int k, input logic [15:0] pat, input int bits, input string nm);
        int n;
        n = 0;
        while (!ready[k] && n < 200) begin
            if (n % CD[k] == CD[k] / 2)
                chk($sformatf("%s_bit%0d", nm, n / CD[k]), 32'(txo[k]), 32'(pat[n / CD[k]]));
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_len", nm), n, bits * CD[k]);
    endtask

    task automatic send_watch(input int k, input logic [8:0] d, input logic [8:0] d_after,
                              input logic [15:0] pat, input int bits, input string nm);
        @(negedge clk);
        valid[k] = 1'b1;
        data[k]  = d;
        @(posedge clk);
        @(negedge clk);
        valid[k] = 1'b0;
        data[k]  = d_after;
        watch(k, pat, bits, nm);
    endtask

    initial begin : stim
        int n;
        for (int k = 0; k < N; k++) data[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_tx%0d", k), 32'(txo[k]), 32'd1);
            chk($sformatf("rst_ready%0d", k), 32'(ready[k]), 32'd1);
            chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        send_watch(0, 9'h055, 9'h0AA, P55,  L8S1, "f55");
        send_watch(1, 9'h000, 9'h0FF, P00,  L8S2, "f00_stop2");
        send_watch(2, 9'h01F, 9'h000, P1F,  L5S1, "f1f_5bit");
        send_watch(0, 9'h0A5, 9'h05A, PA5E, L8S1, "fa5_even");
        send_watch(3, 9'h0A5, 9'h05A, PA5O, L8S1, "fa5_odd");

        // Back-to-back with tx_valid held
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 9'h001;
        @(posedge clk);
        @(negedge clk);
        data[0] = 9'h080;
        n = 0;
        while (!ready[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_len", n, L8S1 * 4);
        @(negedge clk);
        chk("b2b_restart_ready", 32'(ready[0]), 32'd0);
        chk("b2b_restart_start", 32'(txo[0]), 32'd0);
        valid[0] = 1'b0;
        data[0]  = 9'h1FF;
        watch(0, P80, L8S1, "b2b_second");

        // Reset in the middle of frames
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 9'h00F;
        valid[1] = 1'b1;
        data[1]  = 9'h000;
        @(posedge clk);
        @(negedge clk);
        valid = '0;
        repeat (17) @(negedge clk);
        chk("pre_rst_tx1", 32'(txo[1]), 32'd0);
        chk("pre_rst_busy", 32'(busy[1:0]), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(txo), 32'hF);
        chk("async_rst_ready", 32'(ready), 32'hF);
        chk("async_rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        send_watch(0, 9'h03C, 9'h000, P3C, L8S1, "after_rst");

        // Randomised traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < N; k++) begin
                valid[k] = ($urandom_range(0, 3) != 0);
                data[k]  = 9'($urandom);
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        valid = '0;
        n = 0;
        while (ready != '1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_ready", 32'(ready), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
